// File: rtl/middle_pipe.sv
// middle_pipe: two-entry valid/ready register slice.
//
// The main register always holds the oldest beat and drives DataOut.
// The skid register catches one extra beat accepted while the output
// is stalled, which lets DataInRdy come straight from a flop instead of
// depending combinationally on DataOutRdy.
//
// Handshake semantics (both sides): a beat transfers on a rising Clk
// edge where valid and ready are both 1. A producer holding valid high
// keeps its payload stable until the transfer. DataInRdy is 1 exactly
// when the skid register is empty. DataOut, DataOutVld and DataInRdy are
// all driven directly from registers.
//
// Priority at each rising edge: Rstn low, then Clear, then handshakes.
// Clear and reset both void any handshake that coincides with them.
//
// dbg_state exposes the occupancy FSM (0=EMPTY, 1=BUSY, 2=FULL).

module middle_pipe #(
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Rstn,
    input  logic          Clear,
    input  logic [DW-1:0] DataIn,
    input  logic          DataInVld,
    output logic          DataInRdy,
    output logic [DW-1:0] DataOut,
    output logic          DataOutVld,
    input  logic          DataOutRdy,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          out_vld_q, out_vld_d;
    logic          in_rdy_q, in_rdy_d;

    logic          in_acc;
    logic          out_con;

    // Handshake qualifiers use only registered readies/valids.
    assign in_acc  = DataInVld && in_rdy_q;
    assign out_con = out_vld_q && DataOutRdy;

    // Next-state, data-path steering and registered-output precompute.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_acc) begin
                    main_d  = DataIn;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_acc && out_con) begin
                    // Pass-through: old beat leaves, new beat takes its place.
                    main_d = DataIn;
                end else if (in_acc) begin
                    // Output stalled: park the new beat behind the main one.
                    skid_d  = DataIn;
                    state_d = ST_FULL;
                end else if (out_con) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Input is closed here; only a consume moves anything.
                if (out_con) begin
                    main_d  = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush overrides any handshake seen this cycle.
        if (Clear) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end

        // Output flags follow the state we are about to enter, so they can
        // be registered without adding a cycle of latency.
        out_vld_d = (state_d != ST_EMPTY);
        in_rdy_d  = (state_d != ST_FULL);
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            state_q   <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            out_vld_q <= out_vld_d;
            in_rdy_q  <= in_rdy_d;
        end
    end

    assign DataOut    = main_q;
    assign DataOutVld = out_vld_q;
    assign DataInRdy  = in_rdy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_middle_pipe.sv
// tb_middle_pipe: directed and random checks of the middle_pipe slice,
// plus a chained DW=1 -> DW=2 pair run against a source/sink scoreboard.
module tb_middle_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       clear;
  logic [7:0] din;
  logic       din_vld;
  logic       din_rdy;
  logic [7:0] dout;
  logic       dout_vld;
  logic       dout_rdy;
  logic [1:0] dbg_state;

  middle_pipe #(.DW(8)) u_dut (
    .Clk        (clk),
    .Rstn       (rstn),
    .Clear      (clear),
    .DataIn     (din),
    .DataInVld  (din_vld),
    .DataInRdy  (din_rdy),
    .DataOut    (dout),
    .DataOutVld (dout_vld),
    .DataOutRdy (dout_rdy),
    .dbg_state  (dbg_state)
  );

  // chained pair: DW=1 feeds DW=2 (zero-extended)
  logic       ch_rstn;
  logic       ch_clear;
  logic       ch_src;
  logic       ch_src_vld;
  logic       ch_src_rdy;
  logic       ch_mid;
  logic       ch_mid_vld;
  logic       ch_mid_rdy;
  logic [1:0] ch_sink;
  logic       ch_sink_vld;
  logic       ch_sink_rdy;
  logic [1:0] ch_dbg_a;
  logic [1:0] ch_dbg_b;

  middle_pipe #(.DW(1)) u_ch_a (
    .Clk        (clk),
    .Rstn       (ch_rstn),
    .Clear      (ch_clear),
    .DataIn     (ch_src),
    .DataInVld  (ch_src_vld),
    .DataInRdy  (ch_src_rdy),
    .DataOut    (ch_mid),
    .DataOutVld (ch_mid_vld),
    .DataOutRdy (ch_mid_rdy),
    .dbg_state  (ch_dbg_a)
  );

  middle_pipe #(.DW(2)) u_ch_b (
    .Clk        (clk),
    .Rstn       (ch_rstn),
    .Clear      (ch_clear),
    .DataIn     ({1'b0, ch_mid}),
    .DataInVld  (ch_mid_vld),
    .DataInRdy  (ch_mid_rdy),
    .DataOut    (ch_sink),
    .DataOutVld (ch_sink_vld),
    .DataOutRdy (ch_sink_rdy),
    .dbg_state  (ch_dbg_b)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [7:0] exp_q[$];
  logic [1:0] ch_exp_q[$];
  int         n_out = 0;
  int         ch_n_out = 0;

  // Inputs and registered outputs are stable at the falling edge, so this
  // predicts exactly which handshakes the next rising edge performs.
  always @(negedge clk) begin
    logic [7:0] e8;
    logic [1:0] e2;
    if (!rstn || clear) begin
      exp_q.delete();
    end else begin
      if (dout_vld && dout_rdy) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(dout), 32'hffff_ffff);
        end else begin
          e8 = exp_q.pop_front();
          check("sb_data", 32'(dout), 32'(e8));
          n_out++;
        end
      end
      if (din_vld && din_rdy) exp_q.push_back(din);
    end

    if (!ch_rstn) begin
      ch_exp_q.delete();
    end else begin
      if (ch_sink_vld && ch_sink_rdy) begin
        if (ch_exp_q.size() == 0) begin
          check("ch_underflow", 32'(ch_sink), 32'hffff_ffff);
        end else begin
          e2 = ch_exp_q.pop_front();
          check("ch_data", 32'(ch_sink), 32'(e2));
          ch_n_out++;
        end
      end
      if (ch_src_vld && ch_src_rdy) ch_exp_q.push_back({1'b0, ch_src});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    din_vld = 1'b1;
    din     = v;
    step();
    din_vld = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn        = 1'b0;
    clear       = 1'b0;
    din         = 8'd0;
    din_vld     = 1'b0;
    dout_rdy    = 1'b0;
    ch_rstn     = 1'b0;
    ch_clear    = 1'b0;
    ch_src      = 1'b0;
    ch_src_vld  = 1'b0;
    ch_sink_rdy = 1'b0;

    // reset state
    do_reset();
    check("rst_vld", 32'(dout_vld), 32'd0);
    check("rst_rdy", 32'(din_rdy), 32'd1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // back-to-back 5,6,7 with sink always ready
    dout_rdy = 1'b1;
    din_vld  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'(5 + i);
      step();
      check("thru_vld", 32'(dout_vld), 32'd1);
      check("thru_dout", 32'(dout), 32'(5 + i));
      check("thru_rdy", 32'(din_rdy), 32'd1);
    end
    din_vld = 1'b0;
    step();
    check("thru_drain_vld", 32'(dout_vld), 32'd0);

    // stall: A=1 in main, B=2 into skid
    dout_rdy = 1'b0;
    push(8'd1);
    check("busy_state", 32'(dbg_state), 32'd1);
    check("busy_rdy", 32'(din_rdy), 32'd1);
    push(8'd2);
    check("full_state", 32'(dbg_state), 32'd2);
    check("full_rdy", 32'(din_rdy), 32'd0);
    check("full_dout", 32'(dout), 32'd1);
    // FULL with 3 offered and held: must not be taken while not ready
    din_vld = 1'b1;
    din     = 8'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_dout", 32'(dout), 32'd1);
      check("stall_rdy", 32'(din_rdy), 32'd0);
    end
    dout_rdy = 1'b1;
    step();
    check("rel1_dout", 32'(dout), 32'd2);
    check("rel1_rdy", 32'(din_rdy), 32'd1);
    step();               // 2 consumed, 3 accepted in the same edge
    din_vld = 1'b0;
    check("rel2_dout", 32'(dout), 32'd3);
    check("rel2_vld", 32'(dout_vld), 32'd1);
    step();
    check("rel3_vld", 32'(dout_vld), 32'd0);
    check("order_cnt", 32'(n_out), 32'd6);

    // Clear while FULL, with input offered and sink ready
    dout_rdy = 1'b0;
    push(8'd8);
    push(8'd9);
    check("pre_clr_state", 32'(dbg_state), 32'd2);
    clear    = 1'b1;
    din_vld  = 1'b1;
    din      = 8'd4;
    dout_rdy = 1'b1;
    step();
    clear   = 1'b0;
    din_vld = 1'b0;
    check("clr_vld", 32'(dout_vld), 32'd0);
    check("clr_rdy", 32'(din_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("clr_quiet", 32'(dout_vld), 32'd0);
    end

    // Reset mid-stream while FULL
    dout_rdy = 1'b0;
    push(8'd10);
    push(8'd11);
    check("pre_rst_state", 32'(dbg_state), 32'd2);
    rstn     = 1'b0;
    din_vld  = 1'b1;
    din      = 8'd12;
    dout_rdy = 1'b1;
    step();
    rstn    = 1'b1;
    din_vld = 1'b0;
    check("mrst_vld", 32'(dout_vld), 32'd0);
    check("mrst_dout", 32'(dout), 32'd0);
    check("mrst_rdy", 32'(din_rdy), 32'd1);

    // random traffic through the scoreboard
    for (int i = 0; i < 300; i++) begin
      din_vld  = ($urandom_range(0, 3) != 0);
      din      = 8'($urandom_range(0, 255));
      dout_rdy = ($urandom_range(0, 2) != 0);
      step();
    end
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_vld_end", 32'(dout_vld), 32'd0);

    // chained pair: source toggles every 2 cycles, sink ready every 8
    ch_rstn = 1'b0;
    step();
    ch_rstn    = 1'b1;
    ch_src_vld = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ch_src      = 1'((i / 2) % 2);
      ch_sink_rdy = ((i / 8) % 2) == 0;
      step();
    end
    ch_src_vld  = 1'b0;
    ch_sink_rdy = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("ch_drained", 32'(ch_exp_q.size()), 32'd0);
    check("ch_beats_seen", 32'(ch_n_out >= 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
